// File: rtl/fade_ctrl.sv
// Brightness level generator feeding the PWM dimmer: manual pass-through, single fade or breathing.
// Optional FADE_GAMMA_EN maps the linear level through a registered perceptual table.
module fade_ctrl #(
  parameter int unsigned STEP_CYCLES = 6250000,
  parameter int unsigned DWELL_STEPS = 4,
  parameter int unsigned LEVEL_MAX   = 15
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic [1:0] mode,
  input  logic [3:0] manual_level,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] level,
  output logic       off,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned DW = (DWELL_STEPS > 1) ? $clog2(DWELL_STEPS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'((DWELL_STEPS > 0) ? DWELL_STEPS - 1 : 0);
  localparam logic [3:0]    LVL_MAX    = 4'(LEVEL_MAX);

  localparam logic [1:0] MODE_MAN     = 2'b00;
  localparam logic [1:0] MODE_UP      = 2'b01;
  localparam logic [1:0] MODE_DOWN    = 2'b10;
  localparam logic [1:0] MODE_BREATHE = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RAMP_UP, S_RAMP_DOWN, S_DWELL} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [1:0]      mode_q, mode_d;
  logic [3:0]      lin_q, lin_d;
  logic            done_q, done_d;
  logic            tick;
  logic [4:0]      lin_up;

  assign tick   = (presc_q == PRESC_LAST);
  assign lin_up = {1'b0, lin_q} + 5'd1;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    lin_d   = lin_q;
    done_d  = 1'b0;

    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      presc_d = '0;
      dwell_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          presc_d = '0;
          dwell_d = '0;
          if (mode == MODE_MAN) begin
            lin_d = (manual_level > LVL_MAX) ? LVL_MAX : manual_level;
          end else if (start && !stop) begin
            mode_d = mode;
            // A fade that starts at its own endpoint finishes without waiting for a step
            case (mode)
              MODE_UP: begin
                if (lin_q >= LVL_MAX) done_d = 1'b1;
                else                  state_d = S_RAMP_UP;
              end
              MODE_DOWN: begin
                if (lin_q == 4'd0) done_d = 1'b1;
                else               state_d = S_RAMP_DOWN;
              end
              MODE_BREATHE: begin
                if (lin_q >= LVL_MAX) state_d = S_DWELL;
                else                  state_d = S_RAMP_UP;
              end
              default: state_d = S_IDLE;
            endcase
          end else begin
            lin_d = lin_q;
          end
        end

        S_RAMP_UP: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (lin_up >= {1'b0, LVL_MAX}) begin
              lin_d = LVL_MAX;
              if (mode_q == MODE_BREATHE) begin
                state_d = S_DWELL;
                dwell_d = '0;
              end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              lin_d = lin_up[3:0];
            end
          end
        end

        S_RAMP_DOWN: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            if (lin_q <= 4'd1) begin
              lin_d = 4'd0;
              if (mode_q == MODE_BREATHE) begin
                state_d = S_DWELL;
                dwell_d = '0;
              end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            end else begin
              lin_d = lin_q - 4'd1;
            end
          end
        end

        S_DWELL: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          // Zero dwell still passes through this state for a single cycle
          if ((DWELL_STEPS == 0) || (tick && (dwell_q == DWELL_LAST))) begin
            state_d = (lin_q == LVL_MAX) ? S_RAMP_DOWN : S_RAMP_UP;
            presc_d = '0;
            dwell_d = '0;
          end else if (tick) begin
            dwell_d = dwell_q + DW'(1);
          end else begin
            dwell_d = dwell_q;
          end
        end

        default: begin
          state_d = S_IDLE;
          presc_d = '0;
          dwell_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      dwell_q <= '0;
      mode_q  <= MODE_MAN;
      lin_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      lin_q   <= lin_d;
      done_q  <= done_d;
    end
  end

`ifdef FADE_GAMMA_EN
  function automatic logic [3:0] gamma_map(input logic [3:0] x);
    case (x)
      4'd0, 4'd1, 4'd2, 4'd3: gamma_map = 4'd0;
      4'd4, 4'd5, 4'd6:       gamma_map = 4'd1;
      4'd7, 4'd8:             gamma_map = 4'd2;
      4'd9:                   gamma_map = 4'd3;
      4'd10:                  gamma_map = 4'd4;
      4'd11:                  gamma_map = 4'd5;
      4'd12:                  gamma_map = 4'd7;
      4'd13:                  gamma_map = 4'd9;
      4'd14:                  gamma_map = 4'd11;
      default:                gamma_map = 4'd15;
    endcase
  endfunction

  logic [3:0] level_q, level_d;

  always_comb begin
    level_d = gamma_map(lin_q);
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) level_q <= 4'd0;
    else         level_q <= level_d;
  end

  assign level = level_q;
`else
  assign level = lin_q;
`endif

  assign off  = (level == 4'd0);
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_fade_ctrl.sv
// Bench for fade_ctrl: constant-vector table, directed timing sequences and a
// randomized run compared against a countdown-based behavioural model.
module tb_fade_ctrl;

  localparam int STEP  = 4;
  localparam int DWELL = 2;
  localparam int LMAX  = 15;

  localparam int P_IDLE = 0, P_UP = 1, P_DOWN = 2, P_DWELL = 3;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] manual_level = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] level;
  logic       off, busy, done;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int m_phase = P_IDLE, m_lin = 0, m_lvl_g = 0, m_mode = 0;
  int m_wait = 0, m_dwell_left = 0;
  bit m_done = 1'b0;

  fade_ctrl #(.STEP_CYCLES(STEP), .DWELL_STEPS(DWELL), .LEVEL_MAX(LMAX)) dut (
    .CLK(CLK), .RESETN(RESETN), .mode(mode), .manual_level(manual_level),
    .start(start), .stop(stop), .level(level), .off(off), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  function automatic int gam(input int x);
    int t [16] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 3, 4, 5, 7, 9, 11, 15};
    return t[x];
  endfunction

  // expected output level for a linear value held long enough to settle
  function automatic int settled(input int lin);
`ifdef FADE_GAMMA_EN
    return gam(lin);
`else
    return lin;
`endif
  endfunction

  task automatic m_enter(input int p);
    m_phase = p;
    m_wait = STEP;
    m_dwell_left = DWELL;
  endtask

  task automatic m_endpoint();
    if (m_mode == 3) m_enter(P_DWELL);
    else begin
      m_phase = P_IDLE;
      m_done = 1'b1;
    end
  endtask

  task automatic model_edge(input bit r, input int md, input int ml, input bit s, input bit p);
    m_done = 1'b0;
    if (!r) begin
      m_phase = P_IDLE; m_lin = 0; m_lvl_g = 0; m_mode = 0; m_wait = 0; m_dwell_left = 0;
      return;
    end
    m_lvl_g = gam(m_lin);
    if (p && m_phase != P_IDLE) begin
      m_phase = P_IDLE;
      return;
    end
    case (m_phase)
      P_IDLE: begin
        if (md == 0) m_lin = (ml > LMAX) ? LMAX : ml;
        else if (s && !p) begin
          m_mode = md;
          if (md == 1) begin
            if (m_lin == LMAX) m_done = 1'b1; else m_enter(P_UP);
          end else if (md == 2) begin
            if (m_lin == 0) m_done = 1'b1; else m_enter(P_DOWN);
          end else begin
            if (m_lin == LMAX) m_enter(P_DWELL); else m_enter(P_UP);
          end
        end
      end
      P_UP: begin
        m_wait--;
        if (m_wait == 0) begin
          m_wait = STEP;
          m_lin++;
          if (m_lin >= LMAX) begin m_lin = LMAX; m_endpoint(); end
        end
      end
      P_DOWN: begin
        m_wait--;
        if (m_wait == 0) begin
          m_wait = STEP;
          m_lin--;
          if (m_lin <= 0) begin m_lin = 0; m_endpoint(); end
        end
      end
      default: begin
        if (DWELL == 0) m_enter(m_lin == LMAX ? P_DOWN : P_UP);
        else begin
          m_wait--;
          if (m_wait == 0) begin
            m_wait = STEP;
            m_dwell_left--;
            if (m_dwell_left == 0) m_enter(m_lin == LMAX ? P_DOWN : P_UP);
          end
        end
      end
    endcase
  endtask

  function automatic int m_level();
`ifdef FADE_GAMMA_EN
    return m_lvl_g;
`else
    return m_lin;
`endif
  endfunction

  task automatic step(input bit r, input logic [1:0] md, input logic [3:0] ml, input bit s, input bit p);
    RESETN = r; mode = md; manual_level = ml; start = s; stop = p;
    @(posedge CLK);
    model_edge(r, int'(md), int'(ml), s, p);
    #1;
  endtask

  task automatic check(input string tag, input int el, input bit eb, input bit ed);
    bit eo;
    eo = (el == 0);
    n_vec++;
    if (int'(level) != el || off !== eo || busy !== eb || done !== ed) begin
      n_err++;
      $display("FAIL %s: got level=%0d off=%0b busy=%0b done=%0b, want level=%0d off=%0b busy=%0b done=%0b",
               tag, level, off, busy, done, el, eo, eb, ed);
    end
  endtask

  task automatic check_model(input string tag);
    check(tag, m_level(), m_phase != P_IDLE, m_done);
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  typedef struct {
    bit         rst_n;
    logic [1:0] md;
    logic [3:0] ml;
    bit         s;
    bit         p;
    int         lin;
    bit         bz;
    bit         dn;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int hit;
    tbl[0] = '{1'b0, 2'd0, 4'd9,  1'b0, 1'b0, 0,  1'b0, 1'b0};
    tbl[1] = '{1'b1, 2'd0, 4'd9,  1'b0, 1'b0, 9,  1'b0, 1'b0};
    tbl[2] = '{1'b1, 2'd0, 4'd0,  1'b0, 1'b0, 0,  1'b0, 1'b0};
    tbl[3] = '{1'b1, 2'd0, 4'd15, 1'b0, 1'b0, 15, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 2'd0, 4'd12, 1'b0, 1'b0, 12, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 2'd0, 4'd3,  1'b0, 1'b0, 3,  1'b0, 1'b0};
    tbl[6] = '{1'b1, 2'd1, 4'd5,  1'b0, 1'b0, 3,  1'b0, 1'b0};
    tbl[7] = '{1'b1, 2'd0, 4'd6,  1'b1, 1'b0, 6,  1'b0, 1'b0};
    tbl[8] = '{1'b1, 2'd1, 4'd9,  1'b0, 1'b1, 6,  1'b0, 1'b0};

    // each row is held two cycles so the gamma build settles too
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].rst_n, tbl[i].md, tbl[i].ml, tbl[i].s, tbl[i].p);
      step(tbl[i].rst_n, tbl[i].md, tbl[i].ml, tbl[i].s, tbl[i].p);
      check($sformatf("table[%0d]", i), settled(tbl[i].lin), tbl[i].bz, tbl[i].dn);
    end

    // single fade up from 13: done on the 8th cycle after the start edge
    step(1, 2'd0, 4'd13, 0, 0); step(1, 2'd0, 4'd13, 0, 0);
    step(1, 2'd1, 4'd0, 1, 0);
    check_model("fade_up_start");
    hit = -1;
    for (int i = 1; i <= 40 && hit < 0; i++) begin
      step(1, 2'd1, 4'd0, 0, 0);
      check_model($sformatf("fade_up_c%0d", i));
      if (done === 1'b1) hit = i;
    end
    check_int("fade_up_done_cycle", hit, 2 * STEP);
    step(1, 2'd1, 4'd0, 0, 0);
    check("fade_up_after", settled(15), 0, 0);

    // breathing from 0: reach 15 after 60 cycles, never done
    step(1, 2'd0, 4'd0, 0, 0); step(1, 2'd0, 4'd0, 0, 0);
    step(1, 2'd3, 4'd0, 1, 0);
    hit = -1;
    begin
      int dones = 0;
      for (int i = 1; i <= 200; i++) begin
        step(1, 2'd3, 4'd0, 0, 0);
        check_model($sformatf("breathe_c%0d", i));
        if (done === 1'b1) dones++;
        if (hit < 0 && level == 4'd15) hit = i;
      end
      check_int("breathe_done_count", dones, 0);
    end
`ifdef FADE_GAMMA_EN
    check_int("breathe_top_cycle", hit, 15 * STEP + 1);
`else
    check_int("breathe_top_cycle", hit, 15 * STEP);
`endif
    step(1, 2'd3, 4'd0, 0, 1);
    check_model("breathe_stop");

    // fade down from 6, stop on the 9th cycle leaves level 4
    step(1, 2'd0, 4'd6, 0, 0); step(1, 2'd0, 4'd6, 0, 0);
    step(1, 2'd2, 4'd0, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 2'd2, 4'd0, 0, 0);
      check_model($sformatf("fade_dn_c%0d", i));
    end
    step(1, 2'd2, 4'd0, 0, 1);
    check("fade_dn_stopped", settled(4), 0, 0);
    step(1, 2'd2, 4'd0, 0, 0);
    check("fade_dn_hold", settled(4), 0, 0);
    step(1, 2'd2, 4'd0, 1, 1);
    check("start_stop_same", settled(4), 0, 0);
    step(1, 2'd2, 4'd0, 0, 0);
    check("start_stop_after", settled(4), 0, 0);

    // fade down already at 0: done next cycle, no busy
    step(1, 2'd0, 4'd0, 0, 0); step(1, 2'd0, 4'd0, 0, 0);
    step(1, 2'd2, 4'd0, 1, 0);
    check("dn_at_zero_done", 0, 0, 1);
    step(1, 2'd2, 4'd0, 0, 0);
    check("dn_at_zero_after", 0, 0, 0);

    // start pulses while busy must not restart the 10 -> 15 fade
    step(1, 2'd0, 4'd10, 0, 0); step(1, 2'd0, 4'd10, 0, 0);
    step(1, 2'd1, 4'd0, 1, 0);
    hit = -1;
    for (int i = 1; i <= 60 && hit < 0; i++) begin
      step(1, (i == 7) ? 2'd2 : 2'd1, 4'd0, (i == 2 || i == 5 || i == 11), 0);
      check_model($sformatf("busy_start_c%0d", i));
      if (done === 1'b1) hit = i;
    end
    check_int("busy_start_done_cycle", hit, 5 * STEP);

    // randomized traffic against the model
    begin
      logic [1:0] md = 2'd0;
      for (int i = 0; i < 3000; i++) begin
        bit r, s, p;
        r = ($urandom_range(0, 299) != 0);
        if ($urandom_range(0, 24) == 0) md = 2'($urandom_range(0, 3));
        s = ($urandom_range(0, 7) == 0);
        p = ($urandom_range(0, 59) == 0);
        step(r, md, 4'($urandom_range(0, 15)), s, p);
        check_model($sformatf("rand_c%0d", i));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fade_ctrl.md
Name: fade_ctrl

Overview:
Upstream stage of the PWM dimmer. It generates the 4-bit brightness level that the dimmer consumes, in one of three ways:
- manual pass-through of the switch value;
- a single timed fade up or down;
- continuous "breathing" (up, dwell, down, dwell, repeat).

It also flags level 0 so the dimmer stage can gate its output fully off.

Parameters:
- STEP_CYCLES, 6250000, clock cycles per one-LSB level step (62.5 ms at 100 MHz); must be >= 2.
- DWELL_STEPS, 4, number of step periods held at each endpoint in breathe mode; 0 means no dwell.
- LEVEL_MAX, 15, top level; must be <= 15.

Ports:
- CLK  in  1  system clock (100 MHz)
- RESETN  in  1  synchronous reset, active-low
- mode  in  2  00 manual, 01 fade up, 10 fade down, 11 breathe
- manual_level  in  4  level used in manual mode (from SW[3:0])
- start  in  1  single-cycle pulse; begins the selected fade
- stop  in  1  single-cycle pulse; aborts any fade
- level  out  4  brightness value to the dimmer
- off  out  1  high when level == 0
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on single-fade completion

Behaviour:
- Interface: one clock, CLK. Reset is synchronous, active-low, on RESETN. All state changes happen on the rising edge of CLK.
- Reset values: level=0, off=1, busy=0, done=0. State=IDLE, prescaler=0, dwell count=0, latched mode=00.
- States: IDLE, RAMP_UP, RAMP_DOWN, DWELL.
- IDLE, mode==00: level <= manual_level each cycle (1-cycle latency). Values above LEVEL_MAX saturate to LEVEL_MAX.
- IDLE, mode!=00: level holds its last value.
- start in IDLE with mode!=00:
  - mode is latched;
  - 01 -> RAMP_UP, 10 -> RAMP_DOWN, 11 -> RAMP_UP;
  - prescaler cleared; busy rises the next cycle.
- start with mode==00 is ignored. start while busy is ignored.
- Prescaler: counts 0..STEP_CYCLES-1 in RAMP_UP, RAMP_DOWN and DWELL. A tick is the terminal count; the prescaler returns to 0 after it. The first tick occurs STEP_CYCLES cycles after state entry.
- RAMP_UP, on tick: level+1. If the new level == LEVEL_MAX:
  - latched 01 -> IDLE with a done pulse in the same cycle busy falls;
  - latched 11 -> DWELL.
- RAMP_DOWN: mirror of RAMP_UP, with endpoint 0. Latched 10 -> IDLE+done; latched 11 -> DWELL.
- Start already at the endpoint:
  - single fade: completes on the next cycle (done pulse), no tick wait, level unchanged;
  - breathe: goes directly to DWELL.
- DWELL: counts DWELL_STEPS ticks, then enters RAMP_DOWN if level==LEVEL_MAX, else RAMP_UP, with the prescaler cleared. If DWELL_STEPS==0, DWELL lasts exactly one cycle.
- stop: from any state -> IDLE next cycle. level holds; no done pulse; prescaler and dwell count cleared.
- stop and start in the same cycle: stop wins.
- level never wraps; it saturates at 0 and LEVEL_MAX.
- Changes on mode while busy have no effect until the next IDLE.
- Reset mid-fade: all reset values apply on the next edge, regardless of state.
- off is combinational from the level register (off == (level==0)).

Optional Feature:
- Macro: FADE_GAMMA_EN.
- Defined: level is the linear ramp value passed through a registered 16-entry perceptual table. This adds 1 cycle of latency to level and off.
  - Table (index 0..15): 0,0,0,0,1,1,1,2,2,3,4,5,7,9,11,15.
  - Manual mode is also mapped.
  - Endpoint detection and done use the linear (pre-table) value.
- Undefined: level is the linear value; no extra latency.

Test Plan:
- Reset with RESETN=0 for 2 cycles -> level=0, off=1, busy=0, done=0. Then mode=00, manual_level=9 -> level=9 one cycle later, off=0.
- STEP_CYCLES=4, level=13, mode=01, start pulse -> level 14 after 4 cycles, 15 after 8. done pulses for one cycle as level becomes 15; busy=0 thereafter.
- STEP_CYCLES=4, DWELL_STEPS=2, level=0, mode=11, start -> level 0..15 in 60 cycles, holds 15 for 8 cycles, descends to 0, holds 8 cycles, rises again. done never asserts.
- Fade down from 6, stop asserted after 9 cycles -> level=4 and held, busy=0 next cycle, no done. A start with stop in the same cycle -> remains IDLE.
- mode=10 start at level 0 -> done pulse next cycle, level stays 0. start pulsed while busy -> no restart, timing unchanged.
- With FADE_GAMMA_EN: manual_level=12 -> level=7 two cycles later. manual_level=15 -> 15; manual_level=3 -> 0 with off=1.
